uart_fifo_apb: RTL

//  APB-slave UART (8N1) replacing the TX-only mini UART: TX and RX engines, TX/RX FIFOs,

---
 rtl/uart_fifo_apb.sv | 236 +++++++++++++++++++++++
 1 files changed

// File: rtl/uart_fifo_apb.sv
// uart_fifo_apb: APB-slave 8N1 UART with TX/RX FIFOs, runtime baud divisor,
// CTS/RTS flow control, status flags, level IRQ and DMA request.
module uart_fifo_apb #(
    parameter int TX_DEPTH  = 8,
    parameter int RX_DEPTH  = 8,
    parameter int DIV_W     = 16,
    parameter int DIV_RESET = 434
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        apbs_psel,
    input  logic        apbs_penable,
    input  logic        apbs_pwrite,
    input  logic [15:0] apbs_paddr,
    input  logic [31:0] apbs_pwdata,
    output logic [31:0] apbs_prdata,
    output logic        apbs_pready,
    output logic        apbs_pslverr,
    input  logic        rx,
    output logic        tx,
    input  logic        cts,
    output logic        rts,
    output logic        irq,
    output logic        dreq
);
    localparam int TPW = $clog2(TX_DEPTH);
    localparam int RPW = $clog2(RX_DEPTH);
    localparam logic [TPW:0] TX_MAX = (TPW+1)'(TX_DEPTH);
    localparam logic [RPW:0] RX_MAX = (RPW+1)'(RX_DEPTH);
    localparam logic [DIV_W-1:0] ONE = DIV_W'(1);
    localparam logic [DIV_W-1:0] TWO = DIV_W'(2);

    typedef enum logic [1:0] {IDLE, START, DATA, STOP} state_t;

    logic [7:0]       tx_mem_q [TX_DEPTH];
    logic [7:0]       tx_mem_d [TX_DEPTH];
    logic [7:0]       rx_mem_q [RX_DEPTH];
    logic [7:0]       rx_mem_d [RX_DEPTH];
    logic [TPW-1:0]   tx_wp_q, tx_wp_d, tx_rp_q, tx_rp_d;
    logic [TPW:0]     tx_lvl_q, tx_lvl_d;
    logic [RPW-1:0]   rx_wp_q, rx_wp_d, rx_rp_q, rx_rp_d;
    logic [RPW:0]     rx_lvl_q, rx_lvl_d;
    logic [DIV_W-1:0] div_q, div_d;
    logic [4:0]       ctrl_q, ctrl_d;
    logic             ovr_q, ovr_d, ferr_q, ferr_d, rts_q, rts_d, tx_out_q, tx_out_d;
    logic [1:0]       cts_s_q, cts_s_d;
    logic [2:0]       rx_s_q, rx_s_d;
    state_t           tx_st_q, tx_st_d, rx_st_q, rx_st_d;
    logic [DIV_W-1:0] tx_cnt_q, tx_cnt_d, tx_div_q, tx_div_d;
    logic [DIV_W-1:0] rx_cnt_q, rx_cnt_d, rx_div_q, rx_div_d;
    logic [2:0]       tx_bit_q, tx_bit_d, rx_bit_q, rx_bit_d;
    logic [7:0]       tx_sh_q, tx_sh_d, rx_sh_q, rx_sh_d;

    logic        acc, wr, rd;
    logic [1:0]  a;
    logic        tx_full, tx_empty, rx_full, rx_empty;
    logic        tx_push, tx_pop, rx_push, rx_pop, rx_valid, ferr_set, ovr_set;
    logic        tx_end, rx_end, rx_mid, can_start, rx_in, rx_fall;
    logic [31:0] stat, rdata;
    logic        unused_bits;

    assign acc       = apbs_psel & apbs_penable;
    assign wr        = acc & apbs_pwrite;
    assign rd        = acc & ~apbs_pwrite;
    assign a         = apbs_paddr[3:2];
    assign tx_full   = tx_lvl_q == TX_MAX;
    assign tx_empty  = tx_lvl_q == '0;
    assign rx_full   = rx_lvl_q == RX_MAX;
    assign rx_empty  = rx_lvl_q == '0;
    assign tx_push   = wr & (a == 2'd0) & ~tx_full;
    assign rx_pop    = rd & (a == 2'd0) & ~rx_empty;
    assign rx_push   = rx_valid & (~rx_full | rx_pop);
    assign ovr_set   = rx_valid & rx_full & ~rx_pop;
    assign can_start = ctrl_q[0] & ~tx_empty & ~(ctrl_q[4] & cts_s_q[1]);
    assign tx_end    = tx_cnt_q == tx_div_q - ONE;
    assign rx_end    = rx_cnt_q == rx_div_q - ONE;
    assign rx_mid    = rx_cnt_q == (rx_div_q >> 1) - ONE;
    assign rx_in     = rx_s_q[1];
    assign rx_fall   = rx_s_q[2] & ~rx_s_q[1];
    assign cts_s_d   = {cts_s_q[0], cts};
    assign rx_s_d    = {rx_s_q[1:0], rx};
    assign unused_bits = ^{apbs_paddr[15:4], apbs_paddr[1:0], apbs_pwdata};

    assign apbs_pready  = 1'b1;
    assign apbs_pslverr = wr & (a == 2'd0) & tx_full;
    assign tx   = tx_out_q;
    assign rts  = rts_q;
    assign dreq = ~tx_full;
    assign irq  = (ctrl_q[2] & tx_empty) | (ctrl_q[3] & (~rx_empty | ovr_q | ferr_q));

    always_comb begin
        stat = {8'b0, 8'(rx_lvl_q), 8'(tx_lvl_q), 1'b0, tx_st_q != IDLE, ferr_q, ovr_q,
                rx_empty, rx_full, tx_empty, tx_full};
        rdata = a == 2'd0 ? {24'b0, rx_empty ? 8'h00 : rx_mem_q[rx_rp_q]} :
                a == 2'd1 ? stat : a == 2'd2 ? 32'(div_q) : {27'b0, ctrl_q};
        apbs_prdata = rd ? rdata : '0;
    end

    always_comb begin
        tx_mem_d = tx_mem_q;
        rx_mem_d = rx_mem_q;
        if (tx_push) tx_mem_d[tx_wp_q] = apbs_pwdata[7:0];
        if (rx_push) rx_mem_d[rx_wp_q] = rx_sh_q;
        tx_wp_d  = tx_wp_q + TPW'(tx_push);
        tx_rp_d  = tx_rp_q + TPW'(tx_pop);
        tx_lvl_d = tx_lvl_q + (TPW+1)'(tx_push) - (TPW+1)'(tx_pop);
        rx_wp_d  = rx_wp_q + RPW'(rx_push);
        rx_rp_d  = rx_rp_q + RPW'(rx_pop);
        rx_lvl_d = rx_lvl_q + (RPW+1)'(rx_push) - (RPW+1)'(rx_pop);
        div_d    = (wr && a == 2'd2) ? (apbs_pwdata[DIV_W-1:0] < TWO ? TWO : apbs_pwdata[DIV_W-1:0]) : div_q;
        ctrl_d   = (wr && a == 2'd3) ? apbs_pwdata[4:0] : ctrl_q;
        // a flag event in the same cycle as its clear wins
        ovr_d    = (ovr_q & ~(wr && a == 2'd1 && apbs_pwdata[4])) | ovr_set;
        ferr_d   = (ferr_q & ~(wr && a == 2'd1 && apbs_pwdata[5])) | ferr_set;
        rts_d    = rx_full | ~ctrl_q[1];
    end

    always_comb begin
        tx_st_d  = tx_st_q;
        tx_cnt_d = tx_end ? '0 : tx_cnt_q + ONE;
        tx_div_d = tx_div_q;
        tx_bit_d = tx_bit_q;
        tx_sh_d  = tx_sh_q;
        tx_pop   = 1'b0;
        case (tx_st_q)
            START: if (tx_end) tx_st_d = DATA;
            DATA: if (tx_end) begin
                tx_sh_d  = tx_sh_q >> 1;
                tx_bit_d = tx_bit_q + 3'd1;
                if (tx_bit_q == 3'd7) tx_st_d = STOP;
            end
            STOP: if (tx_end) tx_st_d = IDLE;
            default: ;
        endcase
        if (can_start && (tx_st_q == IDLE || (tx_st_q == STOP && tx_end))) begin
            tx_st_d  = START;
            tx_pop   = 1'b1;
            tx_sh_d  = tx_mem_q[tx_rp_q];
            tx_div_d = div_q;
            tx_cnt_d = '0;
            tx_bit_d = '0;
        end
        // line follows the registered state one cycle later
        tx_out_d = tx_st_q == START ? 1'b0 : tx_st_q == DATA ? tx_sh_q[0] : 1'b1;
    end

    always_comb begin
        rx_st_d  = rx_st_q;
        rx_cnt_d = rx_end ? '0 : rx_cnt_q + ONE;
        rx_div_d = rx_div_q;
        rx_bit_d = rx_bit_q;
        rx_sh_d  = rx_sh_q;
        rx_valid = 1'b0;
        ferr_set = 1'b0;
        case (rx_st_q)
            IDLE: if (ctrl_q[1] && rx_fall) begin
                rx_st_d  = START;
                rx_cnt_d = '0;
                rx_div_d = div_q;
            end
            START: if (rx_mid) begin
                rx_st_d  = rx_in ? IDLE : DATA;
                rx_cnt_d = '0;
                rx_bit_d = '0;
            end
            DATA: if (rx_end) begin
                rx_sh_d  = {rx_in, rx_sh_q[7:1]};
                rx_bit_d = rx_bit_q + 3'd1;
                if (rx_bit_q == 3'd7) rx_st_d = STOP;
            end
            default: if (rx_end) begin
                rx_st_d  = IDLE;
                rx_valid = rx_in;
                ferr_set = ~rx_in;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            tx_mem_q <= '{default: '0};
            rx_mem_q <= '{default: '0};
            tx_wp_q  <= '0;
            tx_rp_q  <= '0;
            tx_lvl_q <= '0;
            rx_wp_q  <= '0;
            rx_rp_q  <= '0;
            rx_lvl_q <= '0;
            div_q    <= DIV_W'(DIV_RESET);
            ctrl_q   <= 5'b00011;
            ovr_q    <= 1'b0;
            ferr_q   <= 1'b0;
            rts_q    <= 1'b1;
            tx_out_q <= 1'b1;
            cts_s_q  <= 2'b11;
            rx_s_q   <= 3'b111;
            tx_st_q  <= IDLE;
            tx_cnt_q <= '0;
            tx_div_q <= TWO;
            tx_bit_q <= '0;
            tx_sh_q  <= '0;
            rx_st_q  <= IDLE;
            rx_cnt_q <= '0;
            rx_div_q <= TWO;
            rx_bit_q <= '0;
            rx_sh_q  <= '0;
        end else begin
            tx_mem_q <= tx_mem_d;
            rx_mem_q <= rx_mem_d;
            tx_wp_q  <= tx_wp_d;
            tx_rp_q  <= tx_rp_d;
            tx_lvl_q <= tx_lvl_d;
            rx_wp_q  <= rx_wp_d;
            rx_rp_q  <= rx_rp_d;
            rx_lvl_q <= rx_lvl_d;
            div_q    <= div_d;
            ctrl_q   <= ctrl_d;
            ovr_q    <= ovr_d;
            ferr_q   <= ferr_d;
            rts_q    <= rts_d;
            tx_out_q <= tx_out_d;
            cts_s_q  <= cts_s_d;
            rx_s_q   <= rx_s_d;
            tx_st_q  <= tx_st_d;
            tx_cnt_q <= tx_cnt_d;
            tx_div_q <= tx_div_d;
            tx_bit_q <= tx_bit_d;
            tx_sh_q  <= tx_sh_d;
            rx_st_q  <= rx_st_d;
            rx_cnt_q <= rx_cnt_d;
            rx_div_q <= rx_div_d;
            rx_bit_q <= rx_bit_d;
            rx_sh_q  <= rx_sh_d;
        end
    end
endmodule
